fir_stream_pipe: RTL and testbench

//  Parametrised, fully pipelined N-tap signed FIR with valid/ready streaming on both sides.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_adder_tree.sv | 57 +++++
 rtl/fir_stream_pipe.sv | 152 +++++++++++++++
 tb/tb_fir_stream_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the streaming FIR: width derivation and saturation bounds.
//   clog2   : ceil(log2(v)), evaluated at elaboration
//   acc_w   : accumulator width for an n-tap product sum of dw-bit operands
//   sat_hi  : largest signed value representable in dw bits
//   sat_lo  : smallest signed value representable in dw bits
package fir_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Full-precision products plus one growth bit per tree level, so the tree cannot overflow.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

  function automatic longint sat_hi(input int dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Pipelined binary adder tree: one register level per tree depth.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the pipeline (low = hold every level)
//   flush      : synchronous clear of all levels
//   in_data    : N_IN signed operands of IN_W bits
//   sum_data   : signed sum, IN_W + clog2(N_IN) bits, clog2(N_IN) cycles after in_data
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IN_W = 32,
  localparam int OUT_W = IN_W + clog2(N_IN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        flush,
  input  logic [N_IN-1:0][IN_W-1:0]   in_data,
  output logic [OUT_W-1:0]            sum_data
);

  localparam int L = clog2(N_IN);
  localparam int P = 1 << L;

  // Heap layout: node j has children 2j+1 and 2j+2; indices P-1..2P-2 are the leaves.
  // Every internal node is a register, so each tree depth is one pipeline stage.
  logic [P-1:0][OUT_W-1:0]   leaf;
  logic [P-2:0][OUT_W-1:0]   node_q, node_d;
  logic [2*P-2:0][OUT_W-1:0] tree;

  // Sign-extend products into the tree; odd operand counts are zero-padded.
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N_IN) begin : g_tap
      assign leaf[i] = OUT_W'($signed(in_data[i]));
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  assign tree = {leaf, node_q};

  always_comb begin
    node_d = node_q;
    for (int j = 0; j < P - 1; j++) begin
      node_d[j] = tree[2*j+1] + tree[2*j+2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     node_q <= '0;
    else if (flush) node_q <= '0;
    else if (en)    node_q <= node_d;
  end

  assign sum_data = node_q[0];

endmodule

// File: rtl/fir_stream_pipe.sv
// Fully pipelined N-tap signed FIR with valid/ready streaming on both sides.
//   clk, rst_n        : clock, async active-low reset (clears coefficient banks too)
//   flush             : clear delay line and pipeline, keep coefficients
//   in_valid/in_ready/in_data     : sample input stream
//   out_valid/out_ready/out_data  : rounded, shifted, saturated result stream
//   out_sat           : result was clipped
//   coef_we/coef_addr/coef_wdata  : write shadow coefficient bank
//   coef_commit       : copy shadow bank into active bank
//   coef_rdata        : registered read of shadow[coef_addr]
// Pipeline: delay line -> multiply -> clog2(N) tree levels -> output register.
module fir_stream_pipe
  import fir_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SHIFT  = 0,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  input  logic                  coef_we,
  input  logic [ADDR_W-1:0]     coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_wdata,
  input  logic                  coef_commit,
  output logic [DATA_WIDTH-1:0] coef_rdata
);

  localparam int L      = clog2(N);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int ACC_W  = acc_w(DATA_WIDTH, N);
  localparam int RW     = ACC_W + 1;  // headroom for the rounding add
  localparam int STAGES = L + 2;      // vld_pipe[0] = delay line, [STAGES] = output reg

  localparam logic signed [RW-1:0] RND    = (RW'(1) << OUT_SHIFT) >> 1;  // 0 when OUT_SHIFT = 0
  localparam logic signed [RW-1:0] SAT_HI = RW'(sat_hi(DATA_WIDTH));
  localparam logic signed [RW-1:0] SAT_LO = RW'(sat_lo(DATA_WIDTH));

  logic [N-1:0][DATA_WIDTH-1:0] x_q, x_d;
  logic [N-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [N-1:0][DATA_WIDTH-1:0] active_q, active_d;
  logic [N-1:0][PW-1:0]         prod_q, prod_d;
  logic [STAGES:0]              vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic [DATA_WIDTH-1:0]        coef_rdata_q, coef_rdata_d;

  logic                         stall, accept;
  logic [ACC_W-1:0]             tree_sum;
  logic signed [RW-1:0]         rnd, shf;
  logic [DATA_WIDTH-1:0]        rs_data;
  logic                         rs_sat;

  fir_adder_tree #(.N_IN(N), .IN_W(PW)) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!stall),
    .flush    (flush),
    .in_data  (prod_q),
    .sum_data (tree_sum)
  );

  // Round half up, arithmetic shift, then clip to the output range.
  always_comb begin
    rnd     = RW'($signed(tree_sum)) + RND;
    shf     = rnd >>> OUT_SHIFT;
    rs_data = shf[DATA_WIDTH-1:0];
    rs_sat  = 1'b0;
    if (shf > SAT_HI) begin
      rs_data = SAT_HI[DATA_WIDTH-1:0];
      rs_sat  = 1'b1;
    end else if (shf < SAT_LO) begin
      rs_data = SAT_LO[DATA_WIDTH-1:0];
      rs_sat  = 1'b1;
    end
  end

  always_comb begin
    stall  = vld_pipe_q[STAGES] && !out_ready;
    accept = in_valid && !stall && !flush;

    // Coefficient port runs independently of stall. Commit copies the registered
    // shadow, so a same-cycle write lands in shadow only.
    shadow_d     = shadow_q;
    active_d     = active_q;
    coef_rdata_d = '0;
    for (int i = 0; i < N; i++) begin
      if (coef_addr == ADDR_W'(i)) begin
        coef_rdata_d = shadow_q[i];
        if (coef_we) shadow_d[i] = coef_wdata;
      end
    end
    if (coef_commit) active_d = shadow_q;

    x_d        = x_q;
    prod_d     = prod_q;
    vld_pipe_d = vld_pipe_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (flush) begin
      x_d        = '0;
      prod_d     = '0;
      vld_pipe_d = '0;
      out_data_d = '0;
      out_sat_d  = 1'b0;
    end else if (!stall) begin
      if (accept) x_d = {x_q[N-2:0], in_data};
      for (int i = 0; i < N; i++) begin
        prod_d[i] = PW'($signed(x_q[i])) * PW'($signed(active_q[i]));
      end
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept};
      out_data_d = rs_data;
      out_sat_d  = rs_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      prod_q       <= '0;
      vld_pipe_q   <= '0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      coef_rdata_q <= '0;
    end else begin
      x_q          <= x_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      prod_q       <= prod_d;
      vld_pipe_q   <= vld_pipe_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      coef_rdata_q <= coef_rdata_d;
    end
  end

  assign in_ready   = !stall;
  assign out_valid  = vld_pipe_q[STAGES];
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign coef_rdata = coef_rdata_q;

endmodule

// File: tb/tb_fir_stream_pipe.sv
// Directed bench for fir_stream_pipe: one instance with OUT_SHIFT=0, one with
// OUT_SHIFT=15, sharing all inputs. Outputs are collected into queues on handshake.
module tb_fir_stream_pipe;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [15:0] in_data, coef_wdata;
  logic        coef_we, coef_commit;
  logic [4:0]  coef_addr;

  logic        in_ready_m, out_valid_m, out_sat_m;
  logic [15:0] out_data_m, coef_rdata_m;
  logic        in_ready_r, out_valid_r, out_sat_r;
  logic [15:0] out_data_r, coef_rdata_r;

  fir_stream_pipe #(.N(4), .DATA_WIDTH(16), .OUT_SHIFT(0), .ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_sat(out_sat_m),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .coef_rdata(coef_rdata_m)
  );

  fir_stream_pipe #(.N(4), .DATA_WIDTH(16), .OUT_SHIFT(15), .ADDR_W(5)) u_rnd (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_sat(out_sat_r),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .coef_rdata(coef_rdata_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            rnd;   // 1: check the OUT_SHIFT=15 instance
    logic [0:3][15:0] c;
    logic [0:3][15:0] x;
    logic [0:3][15:0] y;
    logic [0:3]       sat;
  } vec_t;

  vec_t        tbl [9];
  logic [16:0] q_m[$], q_r[$];
  int          n_cmp = 0, n_err = 0;

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (out_valid_m) q_m.push_back({out_sat_m, out_data_m});
      if (out_valid_r) q_r.push_back({out_sat_r, out_data_r});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic [63:0] c, x, y, input logic [3:0] s);
    vec_t v;
    v.rnd = r; v.c = c; v.x = x; v.y = y; v.sat = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    step();
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
  endtask

  task automatic set_coefs(input logic [63:0] c);
    logic [63:0] cv;
    cv = c;
    for (int k = 0; k < 4; k++) wr(5'(k), cv[63-16*k -: 16]);
    commit();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int t;
    in_valid = 1'b1; in_data = d; t = 0;
    @(negedge clk);
    while (!(in_ready_m && in_ready_r) && t < 30) begin
      @(negedge clk); t++;
    end
    if (t >= 30) chk("send_timeout", 32'(in_ready_m), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input bit r);
    int t;
    t = 0;
    while (((r ? q_r.size() : q_m.size()) < n) && t < 40) begin
      step(); t++;
    end
    if (t >= 40) chk("wait_q_timeout", 32'(r ? q_r.size() : q_m.size()), 32'(n));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic [16:0] got;
    do_flush();
    q_m.delete(); q_r.delete();
    for (int k = 0; k < 4; k++) send(v.x[k]);
    wait_q(4, v.rnd);
    for (int k = 0; k < 4; k++) begin
      got = 'x;
      if (v.rnd && q_r.size() > 0) got = q_r.pop_front();
      else if (!v.rnd && q_m.size() > 0) got = q_m.pop_front();
      chk($sformatf("%s[%0d]", nm, k), 32'(got), 32'({v.sat[k], v.y[k]}));
    end
  endtask

  initial begin
    logic [16:0] got;
    int acc;
    int pend;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;

    // Table: {which instance, coefs, samples, expected outputs, expected sat flags}
    tbl[0] = mk(0, 64'h0001_0002_0003_0004, 64'h0001_0000_0000_0000, 64'h0001_0002_0003_0004, 4'b0000);
    tbl[1] = mk(0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 64'h0001_0002_0003_0004, 4'b0000);
    tbl[2] = mk(0, 64'h0002_FFFF_0003_0000, 64'h0005_FFFE_0007_0001, 64'h000A_FFF7_001F_FFF5, 4'b0000);
    tbl[3] = mk(0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 4'b1111);
    tbl[4] = mk(0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 4'b1111);
    tbl[5] = mk(0, 64'h0001_0000_0000_0000, 64'h7FFF_8000_FFFF_0000, 64'h7FFF_8000_FFFF_0000, 4'b0000);
    tbl[6] = mk(0, 64'h0001_0001_0000_0000, 64'h7FFF_0001_8000_FFFF, 64'h7FFF_7FFF_8001_8000, 4'b0101);
    tbl[7] = mk(1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFE_7FFF_7FFF_7FFF, 4'b0111);
    tbl[8] = mk(1, 64'h4000_0000_0000_0000, 64'h0003_FFFD_0001_FFFF, 64'h0002_FFFF_0001_0000, 4'b0000);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid_m), 32'd0);
    chk("rst_out_data", 32'(out_data_m), 32'd0);
    chk("rst_coef_rdata", 32'(coef_rdata_m), 32'd0);
    chk("rst_in_ready", 32'(in_ready_m), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Latency: impulse accepted at E0, out_valid rises after E4
    set_coefs(64'h0001_0002_0003_0004);
    do_flush();
    in_valid = 1'b1; in_data = 16'd1;
    step();
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("lat_valid_e%0d", e), 32'(out_valid_m), 32'(e == 4));
    end
    chk("lat_data", 32'(out_data_m), 32'd1);

    // Shadow bank: uncommitted write has no effect on the datapath
    wr(5'd0, 16'd5);
    run_vec("shadow_nocommit", mk(0, '0, 64'h0001_0000_0000_0000, 64'h0001_0002_0003_0004, 4'b0000));
    coef_addr = 5'd0; step();
    chk("rdata_addr0", 32'(coef_rdata_m), 32'd5);
    wr(5'd4, 16'h1234);
    coef_addr = 5'd4; step();
    chk("rdata_addr4", 32'(coef_rdata_m), 32'd0);
    commit();
    run_vec("shadow_commit", mk(0, '0, 64'h0001_0000_0000_0000, 64'h0005_0002_0003_0004, 4'b0000));
    // Same-cycle write + commit: active gets pre-write shadow {5,9,3,4}
    wr(5'd1, 16'd9);
    coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 16'd7; coef_commit = 1'b1;
    step();
    coef_we = 1'b0; coef_commit = 1'b0;
    run_vec("we_commit", mk(0, '0, 64'h0001_0000_0000_0000, 64'h0005_0009_0003_0004, 4'b0000));
    coef_addr = 5'd0; step();
    chk("rdata_after_wc", 32'(coef_rdata_m), 32'd7);

    // Backpressure: step input, out_ready low for 3 cycles once output starts
    set_coefs(64'h0001_0001_0001_0001);
    do_flush();
    q_m.delete(); q_r.delete();
    acc = 0;
    in_valid = 1'b1; in_data = 16'd1;
    for (int cyc = 0; cyc < 40 && acc < 7; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      @(negedge clk);
      if (cyc >= 5 && cyc <= 7) begin
        chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready_m), 32'd0);
        chk($sformatf("bp_hold_c%0d", cyc), 32'({out_valid_m, out_data_m}), 32'({1'b1, 16'd1}));
      end
      if (in_valid && in_ready_m) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_q(7, 0);
    for (int k = 0; k < 5; k++) step();
    chk("bp_count", 32'(q_m.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      got = 'x;
      if (q_m.size() > 0) got = q_m.pop_front();
      chk($sformatf("bp_seq[%0d]", k), 32'(got), 32'((k < 3) ? k + 1 : 4));
    end

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      set_coefs(tbl[i].c);
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Flush mid-run drops pending samples; flush beats a same-cycle accept
    do_flush();
    q_m.delete(); q_r.delete();
    send(16'd3);
    send(16'd3);
    in_valid = 1'b1; in_data = 16'd3; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 10; k++) step();
    pend = q_m.size() + q_r.size();
    chk("flush_drop", 32'(pend), 32'd0);
    chk("flush_valid", 32'(out_valid_r), 32'd0);

    // Async reset mid-stream with a held output and nonzero coefficients
    set_coefs(64'h0001_0001_0001_0001);
    coef_addr = 5'd0;
    out_ready = 1'b0;
    send(16'd1);
    for (int k = 0; k < 8; k++) step();
    chk("pre_rst_valid", 32'({out_valid_m, out_data_m, coef_rdata_m}), 32'({1'b1, 16'd1, 16'd1}));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid_m), 32'd0);
    chk("async_rst_data", 32'(out_data_m), 32'd0);
    chk("async_rst_rdata", 32'(coef_rdata_m), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready_m), 32'd1);
    chk("post_rst_shadow", 32'(coef_rdata_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
